// File: rtl/leg_fetch.sv
// leg_fetch: instruction fetch stage for the LEG core.
//
// Issues sequential byte fetches to program memory, one request in flight at a time, and
// buffers the returned bytes (tagged with their address) in a small FIFO. The FIFO head is
// offered downstream over a valid/ready handshake. A redirect flushes the FIFO, restarts
// fetching at the new address and drops any response that was already in flight.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   o_mem_req/o_mem_addr one-cycle fetch request and its address
//   i_mem_rvalid/rdata   in-order read response, one per request
//   o_inst_valid/o_inst/o_inst_pc/i_inst_ready  head of the instruction FIFO
//   i_redirect/i_redirect_pc                    flush and restart at a new address
module leg_fetch #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rvalid,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_inst_valid,
  output logic [7:0]        o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  // FIFO storage
  logic [7:0]        byte_q [DEPTH];
  logic [ADDR_W-1:0] ipc_q  [DEPTH];

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              outstanding_q, outstanding_d;
  logic              discard_q, discard_d;
  // Low during reset and the partial cycle after release, so no request is shown in reset.
  logic              run_q;

  logic mem_req;
  logic pop;
  logic accept;
  logic push;

  always_comb begin
    mem_req = run_q && !outstanding_q && !discard_q && (count_q < CntW'(DEPTH));
    pop     = (count_q != '0) && i_inst_ready;
    // A response only counts when it answers the request in flight.
    accept  = i_mem_rvalid && outstanding_q;
    push    = accept && !discard_q && !i_redirect;
  end

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (i_redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = i_redirect_pc;
      if (accept) begin
        // The response closes the only request in flight (stale or not): nothing left to drop.
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end else if (outstanding_q) begin
        discard_d = 1'b1;
      end else if (mem_req) begin
        // The request going out this cycle belongs to the old stream.
        outstanding_d = 1'b1;
        discard_d     = 1'b1;
      end
    end else begin
      if (mem_req) begin
        outstanding_d = 1'b1;
        req_pc_d      = pc_q;
        pc_d          = pc_q + ADDR_W'(1);
      end
      if (accept) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (push) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      pc_q          <= ResetPc;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      run_q         <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        byte_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
    end else if (push) begin
      byte_q[tail_q] <= i_mem_rdata;
      ipc_q[tail_q]  <= req_pc_q;
    end
  end

  always_comb begin
    o_mem_req    = mem_req;
    o_mem_addr   = pc_q;
    o_inst_valid = (count_q != '0);
    o_inst       = byte_q[head_q];
    o_inst_pc    = ipc_q[head_q];
  end

endmodule

// File: doc/leg_fetch.md
# leg_fetch

Instruction fetch stage for the LEG core. It generates sequential byte-wide instruction fetches to program memory and buffers the returned bytes in a small FIFO. It presents each buffered instruction, tagged with its address, to the decode/execute stage over a valid/ready handshake. On a redirect (jump or branch) it flushes buffered and in-flight instructions and restarts fetching at the new address.

## Interface
- ADDR_W, 4, program-address width; the PC wraps modulo 2^ADDR_W
- DEPTH, 4, instruction FIFO depth; power of two, ≥2
- RESET_PC, 0, fetch address after reset
- i_clk  in  1  single clock; all state updates on its rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- o_mem_req  out  1  one-cycle fetch request to program memory
- o_mem_addr  out  ADDR_W  address of the request; valid when o_mem_req=1
- i_mem_rvalid  in  1  read data valid; one pulse per request, in order, ≥1 cycle after the request
- i_mem_rdata  in  8  instruction byte
- o_inst_valid  out  1  FIFO head holds an instruction
- o_inst  out  8  instruction byte at the FIFO head
- o_inst_pc  out  ADDR_W  address of o_inst
- i_inst_ready  in  1  consumer accepts the head; a transfer occurs when valid&&ready
- i_redirect  in  1  flush and restart fetching (one-cycle pulse)
- i_redirect_pc  in  ADDR_W  new fetch address

## Operation
- State: fetch PC r_pc; FIFO storing {byte, pc} with a head pointer, tail pointer and count (0..DEPTH); r_outstanding (one request in flight); r_req_pc; r_discard (in-flight response must be dropped).
- At most one outstanding request.
- o_mem_req is decoded from registers only: !r_outstanding && !r_discard && (count < DEPTH).
- Credit rule: the FIFO can never overflow, because a request is issued only when a slot is free and no other request is pending.
- When o_mem_req=1: o_mem_addr=r_pc; next cycle r_outstanding=1, r_req_pc=r_pc, r_pc=r_pc+1 (mod 2^ADDR_W; max address wraps to 0).
- On i_mem_rvalid with r_discard=0: push {i_mem_rdata, r_req_pc} and clear r_outstanding.
- On i_mem_rvalid with r_discard=1: drop the data and clear both r_outstanding and r_discard.
- i_mem_rvalid while no request is outstanding is ignored.
- Pop: when o_inst_valid && i_inst_ready, advance the head pointer.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on empty cannot occur because valid=0.
- o_inst_valid = (count≠0). o_inst and o_inst_pc come directly from the head entry and are stable while valid=1 and ready=0.
- Redirect, i_redirect=1 at a cycle edge:
  - The FIFO empties: count=0, head=tail.
  - r_pc = i_redirect_pc.
  - If a request is outstanding, or o_mem_req is asserted in the same cycle, r_discard=1.
  - Any i_mem_rvalid arriving in the redirect cycle is dropped. If it satisfies the only outstanding request, r_discard stays 0.
  - A handshake (valid&&ready) in the redirect cycle counts as consumed by the downstream stage; it has no effect on the flush.
- Redirect while r_discard=1: r_pc is updated; r_discard stays 1 until the stale response returns.
- Back-to-back redirects: the last one wins.

## Timing
- Reset values, asynchronous, while i_rst_n=0:
  - o_mem_req=0, o_mem_addr=RESET_PC, o_inst_valid=0, o_inst=0, o_inst_pc=0.
  - count=0, r_outstanding=0, r_discard=0, r_pc=RESET_PC.
- Reset asserted mid-operation discards all state immediately. A memory response arriving after reset release with no request outstanding is ignored.
- First o_mem_req is in the first clock cycle after reset deassertion.
- Memory latency L: request at cycle n, i_mem_rvalid at n+L, o_inst_valid at n+L+1.
- Next request at n+L+1; sustained throughput is 1 instruction per L+1 cycles.
- Redirect at cycle r:
  - o_inst_valid=0 from r+1.
  - With nothing outstanding, a request to i_redirect_pc at r+1.
  - With a discard pending, a request in the cycle after the stale response.
- FIFO full with ready=0: o_mem_req stays 0.
- Popping a full FIFO at cycle k makes o_mem_req=1 at k+1.

## Test plan
- Reset release, memory returns 0x57, 0x51, 0x21 at L=1 for addresses 0, 1, 2, ready=1.
  - Requests at cycles 0, 2, 4.
  - Instructions {0x57,pc0}, {0x51,pc1}, {0x21,pc2} each valid for one cycle, at cycles 2, 4, 6.
- ready=0, L=1, DEPTH=4:
  - Exactly 4 requests (addresses 0–3), then o_mem_req held 0 with count=4 and the head stable at {byte0, pc0}.
  - Raising ready for one cycle yields one request for address 4 on the next cycle.
- Wrap: RESET_PC=14, ADDR_W=4. Fetch addresses are 14, 15, 0, 1; o_inst_pc follows the same order.
- Redirect to 9 while a request for address 3 is outstanding at L=3:
  - FIFO empties next cycle.
  - The address-3 response is dropped and never appears at o_inst.
  - The next request, for address 9, is issued the cycle after that response.
- Redirect coincident with i_mem_rvalid (only outstanding request) and a pop:
  - The byte is dropped and the popped instruction counts as consumed.
  - Request for the new PC on the next cycle; r_discard=0.
- Assert i_rst_n=0 mid-stream with count=3 and a request outstanding:
  - Outputs go to reset values immediately.
  - After release, the late rvalid is ignored and fetching restarts at RESET_PC.
